load_unit: RTL and testbench

//  RV32I load path: the read-side counterpart of the store lane-placement logic.

---
 rtl/load_unit.sv | 139 +++++++++++++
 tb/tb_load_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// RV32I load unit: one word-aligned read per load, then lane extract and extend.
// Optional build macro MISALIGN_TRAP_EN traps misaligned LH/LHU/LW at accept.
module load_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, FAULT, DRAIN} stateE;

  stateE         state;
  logic [31:0]   addrQ;
  logic [2:0]    funct3Q;
  logic [4:0]    rdQ;
  logic [CW-1:0] cnt;
  logic          rdEnQ, wbValidQ, faultQ;
  logic          illegal, misalign, tHit;

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] lane,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lane, 3'b000} +: 8];
    h = d[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign tHit = (TIMEOUT != 0) && (cnt == CW'(TLIM));

  assign req_ready = (state == IDLE) && !flush;
  assign mem_rd_en = rdEnQ;
  // Strobes are registered on state entry; a kill in the strobe cycle masks them.
  assign wb_valid  = wbValidQ && !flush;
  assign fault     = faultQ && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addrQ      <= '0;
      funct3Q    <= '0;
      rdQ        <= '0;
      cnt        <= '0;
      rdEnQ      <= 1'b0;
      wbValidQ   <= 1'b0;
      faultQ     <= 1'b0;
      mem_addr   <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
      fault_addr <= '0;
    end else begin
      rdEnQ    <= 1'b0;
      wbValidQ <= 1'b0;
      faultQ   <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          addrQ   <= req_addr;
          funct3Q <= req_funct3;
          rdQ     <= req_rd;
          if (illegal || misalign) begin
            state      <= FAULT;
            faultQ     <= 1'b1;
            fault_addr <= req_addr;
          end else begin
            state    <= REQ;
            rdEnQ    <= 1'b1;
            mem_addr <= {req_addr[31:2], 2'b00};
          end
        end
        REQ: begin
          cnt   <= '0;
          state <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              wb_data  <= extract(mem_rdata, addrQ[1:0], funct3Q);
              wb_rd    <= rdQ;
              wbValidQ <= 1'b1;
              state    <= RESP;
            end
          end else if (flush) begin
            // Drain gets a fresh timeout budget for the read still in flight.
            cnt   <= '0;
            state <= tHit ? IDLE : DRAIN;
          end else if (tHit) begin
            state      <= FAULT;
            faultQ     <= 1'b1;
            fault_addr <= addrQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:  state <= IDLE;
        FAULT: state <= IDLE;
        DRAIN: begin
          if (mem_rvalid || tHit) state <= IDLE;
          else                    cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected memory reads and
// writeback/fault events; a negedge monitor pops and compares them.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, mem_rvalid;
  logic        req_ready, mem_rd_en, wb_valid, fault;
  logic [31:0] req_addr, mem_addr, mem_rdata, wb_data, fault_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd, wb_rd;

  int asserts = 0;
  int fails   = 0;

  typedef struct {
    bit          isFault;
    logic [4:0]  rd;
    logic [31:0] val;
  } evT;

  evT          expQ[$];
  logic [31:0] memQ[$];
  evT          mEv;
  logic [31:0] mAddr;

  always #5 clk = ~clk;

  load_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_rd(req_rd),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_addr(fault_addr)
  );

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        asserts++;
        if (memQ.size() == 0) begin
          fails++;
          $display("FAIL mem_rd_en unexpected: mem_addr=%h", mem_addr);
        end else begin
          mAddr = memQ.pop_front();
          if (mem_addr !== mAddr) begin
            fails++;
            $display("FAIL mem_addr actual=%h required=%h", mem_addr, mAddr);
          end
        end
      end
      if (wb_valid) begin
        asserts++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL wb_valid unexpected: rd=%0d data=%h", wb_rd, wb_data);
        end else begin
          mEv = expQ.pop_front();
          if (mEv.isFault || wb_rd !== mEv.rd || wb_data !== mEv.val) begin
            fails++;
            $display("FAIL writeback actual rd=%0d data=%h required fault=%0b rd=%0d data=%h",
                     wb_rd, wb_data, mEv.isFault, mEv.rd, mEv.val);
          end
        end
      end
      if (fault) begin
        asserts++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL fault unexpected: fault_addr=%h", fault_addr);
        end else begin
          mEv = expQ.pop_front();
          if (!mEv.isFault || fault_addr !== mEv.val) begin
            fails++;
            $display("FAIL fault actual addr=%h required fault=%0b addr=%h",
                     fault_addr, mEv.isFault, mEv.val);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Returns one ns into the cycle after the accepting edge (the REQ/FAULT cycle).
  task automatic accept(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r);
    int n;
    n = 0;
    req_valid = 1'b1; req_addr = a; req_funct3 = f; req_rd = r;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      asserts++;
      fails++;
      $display("FAIL accept_timeout actual req_ready=0 required 1 within 50 cycles");
    end
    nextCycle();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input int lat);
    repeat (lat) nextCycle();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    nextCycle();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic pushWb(input logic [31:0] a, input logic [4:0] r, input logic [31:0] v);
    evT e;
    e.isFault = 1'b0; e.rd = r; e.val = v;
    memQ.push_back({a[31:2], 2'b00});
    expQ.push_back(e);
  endtask

  task automatic pushFault(input logic [31:0] a);
    evT e;
    e.isFault = 1'b1; e.rd = 5'd0; e.val = a;
    expQ.push_back(e);
  endtask

  task automatic doLoad(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                        input logic [31:0] d, input int lat, input bit expFault,
                        input logic [31:0] expVal);
    if (expFault) pushFault(a);
    else          pushWb(a, r, expVal);
    accept(a, f, r);
    if (!expFault) respond(d, lat);
    repeat (2) nextCycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; mem_rvalid = 1'b0;
    req_addr = '0; req_funct3 = '0; req_rd = '0; mem_rdata = '0;
    repeat (3) nextCycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    nextCycle();

    // Lane extraction and extension
    doLoad(32'h1003, 3'b000, 5'd5,  32'h80123456, 1, 0, 32'hFFFFFF80);
    doLoad(32'h2002, 3'b101, 5'd6,  32'hBEEF1234, 2, 0, 32'h0000BEEF);
    doLoad(32'h2002, 3'b001, 5'd7,  32'hBEEF1234, 1, 0, 32'hFFFFBEEF);
    doLoad(32'h2001, 3'b100, 5'd8,  32'hBEEF1234, 3, 0, 32'h00000012);
    doLoad(32'h2000, 3'b000, 5'd9,  32'h0000007F, 1, 0, 32'h0000007F);
    doLoad(32'h2000, 3'b001, 5'd10, 32'h12348001, 1, 0, 32'hFFFF8001);
    doLoad(32'h2003, 3'b100, 5'd11, 32'hAB000000, 2, 0, 32'h000000AB);
    doLoad(32'h0090, 3'b100, 5'd0,  32'h000000FF, 1, 0, 32'h000000FF);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    doLoad(32'h3001, 3'b010, 5'd9,  32'hCAFEF00D, 1, 1, 32'h3001);
    doLoad(32'h3003, 3'b001, 5'd12, 32'h8765AAAA, 1, 1, 32'h3003);
`else
    doLoad(32'h3001, 3'b010, 5'd9,  32'hCAFEF00D, 1, 0, 32'hCAFEF00D);
    doLoad(32'h3003, 3'b001, 5'd12, 32'h8765AAAA, 1, 0, 32'hFFFF8765);
`endif

    // Illegal funct3: fault the cycle after accept, no read
    pushFault(32'h44);
    accept(32'h44, 3'b011, 5'd3);
    @(negedge clk);
    chk("illegal_fault_n1", fault, 1);
    chk("illegal_no_rd_en", mem_rd_en, 0);
    repeat (2) nextCycle();
    doLoad(32'h48, 3'b110, 5'd3, 32'h0, 1, 1, 32'h48);

    // Minimum latency: wb_valid at N+3
    pushWb(32'h40, 5'd10, 32'h11223344);
    accept(32'h40, 3'b010, 5'd10);
    respond(32'h11223344, 1);
    @(negedge clk);
    chk("lat_wb_valid_n3", wb_valid, 1);
    repeat (2) nextCycle();

    // Timeout after 4 WAIT cycles
    memQ.push_back(32'h50);
    pushFault(32'h50);
    accept(32'h50, 3'b010, 5'd11);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("timeout_quiet_n%0d", k), fault, 0);
      nextCycle();
    end
    @(negedge clk);
    chk("timeout_fault_n6", fault, 1);
    nextCycle();
    @(negedge clk);
    chk("timeout_ready_n7", req_ready, 1);
    nextCycle();

    // Flush in WAIT, drain response 3 cycles later
    memQ.push_back(32'h60);
    accept(32'h60, 3'b010, 5'd12);
    nextCycle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_wait", req_ready, 0);
    nextCycle();
    flush = 1'b0;
    @(negedge clk);
    chk("drain_ready_1", req_ready, 0);
    nextCycle();
    @(negedge clk);
    chk("drain_ready_2", req_ready, 0);
    nextCycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADDEAD;
    @(negedge clk);
    chk("drain_ready_rvalid", req_ready, 0);
    nextCycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("drain_ready_after", req_ready, 1);
    nextCycle();
    doLoad(32'h70, 3'b010, 5'd13, 32'h0BADBEEF, 1, 0, 32'h0BADBEEF);

    // Flush in RESP suppresses writeback
    memQ.push_back(32'h80);
    accept(32'h80, 3'b010, 5'd14);
    nextCycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55555555;
    nextCycle();
    mem_rvalid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_resp_no_wb", wb_valid, 0);
    nextCycle();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_resp_ready", req_ready, 1);

    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1;
    nextCycle();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_no_wb", wb_valid, 0);
    nextCycle();

    // Reset mid-load
    memQ.push_back(32'hA0);
    accept(32'hA0, 3'b010, 5'd15);
    nextCycle();
    rst = 1'b1;
    repeat (2) nextCycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_wb_data", wb_data, 0);
    chk("midrst_wb_rd", wb_rd, 0);
    chk("midrst_fault_addr", fault_addr, 0);
    repeat (3) nextCycle();

    chk("exp_queue_drained", expQ.size(), 0);
    chk("mem_queue_drained", memQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
